// File: rtl/lfp_dot_accum_e5m3_if.sv
// Handshake bundle between the E5M3 product stream, the dot-product accumulator
// and the gate activation logic that consumes its results.
interface lfp_dot_accum_e5m3_if #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface

// File: rtl/lfp_dot_accum_e5m3.sv
// Streaming saturating accumulator for E5M3 log-domain products.
// S1 decodes a product into a 36-bit signed fixed-point term (LSB = 2^-17),
// S2 sums terms and emits the result, term count and sticky saturation flag
// on the last term of each vector. The next vector starts with no bubble.
module lfp_dot_accum_e5m3 #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lfp_dot_accum_e5m3_if.slave   bus
);
    localparam int TERM_W = 36;

    logic                    s1_valid;
    logic                    s1_last;
    logic signed [TERM_W-1:0] s1_term;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    sat_sticky;

    logic                    out_valid_q;
    logic [ACC_W-1:0]        out_data_q;
    logic [CNT_W-1:0]        out_count_q;
    logic                    out_sat_q;

    logic                    stall;
    logic                    accept;
    logic [TERM_W-1:0]       mag;
    logic signed [TERM_W-1:0] dec_term;
    logic [ACC_W:0]          sum_ext;
    logic                    pos_ov;
    logic                    neg_ov;
    logic [ACC_W-1:0]        sum_clamped;
    logic [CNT_W-1:0]        cnt_inc;

    // A pending last term cannot move into an output register that is still
    // waiting for its consumer; everything upstream freezes instead.
    assign stall        = s1_valid && s1_last && out_valid_q && !bus.out_ready;
    assign accept       = bus.in_valid && !stall;
    assign bus.in_ready = !stall;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

    // Decode: exact shift of the implicit-one mantissa; E == 0 is a true zero.
    always_comb begin
        mag      = {{(TERM_W-4){1'b0}}, 1'b1, bus.in_data[2:0]} << bus.in_data[7:3];
        dec_term = '0;
        if (bus.in_data[7:3] != 5'd0) begin
            dec_term = bus.in_data[8] ? -$signed(mag) : $signed(mag);
        end
    end

    // S1 register: holds its contents while the output side is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_term  <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            s1_last  <= bus.in_last;
            s1_term  <= dec_term;
        end
    end

    // Sum at one extra bit so overflow shows up as disagreeing top bits.
    always_comb begin
        sum_ext     = {acc[ACC_W-1], acc}
                    + {{(ACC_W+1-TERM_W){s1_term[TERM_W-1]}}, s1_term};
        pos_ov      = (sum_ext[ACC_W:ACC_W-1] == 2'b01);
        neg_ov      = (sum_ext[ACC_W:ACC_W-1] == 2'b10);
        sum_clamped = sum_ext[ACC_W-1:0];
        if (pos_ov) begin
            sum_clamped = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (neg_ov) begin
            sum_clamped = {1'b1, {(ACC_W-1){1'b0}}};
        end
        cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    // S2: accumulate, and on the last term publish the result and clear state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            sat_sticky  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (s1_valid && !stall) begin
                if (s1_last) begin
                    out_data_q  <= sum_clamped;
                    out_count_q <= cnt_inc;
                    out_sat_q   <= sat_sticky | pos_ov | neg_ov;
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                    sat_sticky  <= 1'b0;
                end else begin
                    acc         <= $signed(sum_clamped);
                    cnt         <= cnt_inc;
                    sat_sticky  <= sat_sticky | pos_ov | neg_ov;
                end
            end
        end
    end
endmodule
